vector_mem_sequencer: RTL and testbench
=======================================

Name: vector_mem_sequencer

Overview:
Memory-stage sequencer for vector loads and stores. It serialises one 128-bit vector, 8 lanes of 16 bits, into 8 consecutive 16-bit accesses on a single-port synchronous RAM. It sits between the Execute-Memory pipeline register and the data RAM, and returns the assembled load vector to the Memory-Writeback register. It holds the pipeline with a stall output while an access is in progress.

Parameters:
DATA_W, 16, lane and RAM word width
LANES, 8, lanes per vector; vector width is DATA_W*LANES = 128
ADDR_W, 16, RAM address width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
req_valid  input  1  vector access request from Execute-Memory register
req_write  input  1  1 = vector store, 0 = vector load; sampled with req_valid
base_addr  input  ADDR_W  address of lane 0
vector_wdata  input  128  store data; lane k = bits [16k+15:16k]
req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid && req_ready
stall  output  1  pipeline hold; high in WRITE, READ and DRAIN
mem_address  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_wren  output  1  RAM write enable
mem_rdata  input  DATA_W  RAM read data; registered, valid the cycle after its address
vector_rdata  output  128  assembled load vector; holds value until the next load completes
done  output  1  one-cycle pulse when the access completes

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, lane counter=0, all latches cleared.
  - req_ready=1, stall=0, mem_wren=0, mem_address=0, mem_wdata=0, vector_rdata=0, done=0.
  - Reset mid-operation aborts the access with no further RAM writes. Lanes already written stay written.
- States: IDLE, WRITE, READ, DRAIN, DONE. Lane counter k is 3 bits.
- IDLE:
  - On acceptance, latch base_addr, req_write and vector_wdata. Upstream may change them afterwards.
  - k=0. Go to WRITE if req_write, else READ.
- WRITE (cycles 1..8 after acceptance):
  - mem_address = base+k, mem_wdata = latched lane k, mem_wren=1.
  - k increments each cycle. After k==7, go to DONE.
- READ (cycles 1..8):
  - mem_address = base+k, mem_wren=0.
  - On each edge with k>=1, capture mem_rdata into lane k-1.
  - After k==7, go to DRAIN.
- DRAIN (cycle 9): capture mem_rdata into lane 7, mem_wren=0, go to DONE.
- DONE:
  - done=1, stall=0, req_ready=0; next state is IDLE.
  - For a load, vector_rdata shows all 8 lanes during DONE. vector_rdata updates atomically from a shadow register at the DRAIN→DONE edge, so partial vectors are never visible.
- Latency from acceptance edge to done:
  - store: done in cycle 9;
  - load: done in cycle 10;
  - back-to-back requests: next acceptance no earlier than cycle 10 (store) or 11 (load).
- Address arithmetic is modulo 2^ADDR_W: base 0xFFFE gives lanes at 0xFFFE, 0xFFFF, 0x0000 … 0x0005.
- req_valid while req_ready==0 is ignored, with no queuing; upstream holds it because stall is asserted.
- Outside WRITE, mem_wren=0 and mem_wdata=0. In IDLE and DONE, mem_address=0.
- A store never modifies vector_rdata.

Test Plan:
1. Store: base=0x0010, vector_wdata=0x0008_0007_0006_0005_0004_0003_0002_0001 → mem_wren high exactly 8 cycles; addresses 0x10..0x17 carry data 1..8 in order; done in cycle 9; stall high cycles 1–8.
2. Load from a RAM model preloaded with 0x10..0x17 = 0xA0..0xA7 → vector_rdata = 0x00A7_00A6_…_00A0 during DONE (cycle 10); mem_wren never high; done pulse exactly 1 cycle.
3. Wrap-around: store base=0xFFFD → addresses FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003, 0004; a follow-up load from 0xFFFD returns the identical vector.
4. Busy rejection: second request (load, base 0x40) asserted during cycle 3 of a store → ignored (req_ready=0); the first store completes unchanged; the second is accepted only after returning to IDLE.
5. Reset mid-load: reset low in cycle 5 → next cycle IDLE, mem_address=0, vector_rdata=0, done never pulses; a new store accepted immediately after reset release completes normally.
6. Input stability: vector_wdata changed to all-ones one cycle after acceptance → RAM still receives the originally latched lanes.

Source files
------------

// File: rtl/vector_mem_sequencer_if.sv
// vector_mem_sequencer_if: request, RAM and result signals of the vector memory sequencer
interface vector_mem_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int ADDR_W = 16
);
  logic                     req_valid;
  logic                     req_write;
  logic [ADDR_W-1:0]        base_addr;
  logic [DATA_W*LANES-1:0]  vector_wdata;
  logic                     req_ready;
  logic                     stall;
  logic [ADDR_W-1:0]        mem_address;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_wren;
  logic [DATA_W-1:0]        mem_rdata;
  logic [DATA_W*LANES-1:0]  vector_rdata;
  logic                     done;
  modport slave (
    input  req_valid, req_write, base_addr, vector_wdata, mem_rdata,
    output req_ready, stall, mem_address, mem_wdata, mem_wren, vector_rdata, done
  );
  modport master (
    output req_valid, req_write, base_addr, vector_wdata, mem_rdata,
    input  req_ready, stall, mem_address, mem_wdata, mem_wren, vector_rdata, done
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: serialises one vector load/store into per-lane accesses on a single-port RAM
module vector_mem_sequencer #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int ADDR_W = 16
) (
  input logic                  clk,
  input logic                  reset,
  vector_mem_sequencer_if.slave bus
);
  localparam int KW = $clog2(LANES);
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;
  state_e                        state_q, state_d;
  logic [KW-1:0]                 k_q, k_d;
  logic [ADDR_W-1:0]             base_q;
  logic [LANES-1:0][DATA_W-1:0]  wdata_q, shadow_q, rdata_q;
  logic                          accept, last;
  assign accept = state_q == IDLE && bus.req_valid;
  assign last   = k_q == KW'(LANES - 1);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? (bus.req_write ? WRITE : READ) : IDLE;
      WRITE:   state_d = last ? DONE : WRITE;
      READ:    state_d = last ? DRAIN : READ;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    k_d = (state_q == WRITE || state_q == READ) ? k_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        base_q  <= bus.base_addr;
        wdata_q <= bus.vector_wdata;
      end
      // RAM data lags its address by one cycle, so lane k-1 lands while lane k is addressed
      if (state_q == READ && k_q != '0) shadow_q[k_q - 1'b1] <= bus.mem_rdata;
      if (state_q == DRAIN) rdata_q <= {bus.mem_rdata, shadow_q[LANES-2:0]};
    end
  end
  assign bus.req_ready    = state_q == IDLE;
  assign bus.stall        = state_q inside {WRITE, READ, DRAIN};
  assign bus.done         = state_q == DONE;
  assign bus.mem_wren     = state_q == WRITE;
  assign bus.mem_address  = (state_q inside {WRITE, READ}) ? base_q + ADDR_W'(k_q) : '0;
  assign bus.mem_wdata    = state_q == WRITE ? wdata_q[k_q] : '0;
  assign bus.vector_rdata = rdata_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: directed and random vector loads/stores against a RAM model and a reference memory
module tb_vector_mem_sequencer;
  logic clk, rst_n;
  int total, bad;
  logic [127:0] vrd_ref, wd;
  logic [15:0] ram [65536];
  bit valid [65536];
  logic bd_we;
  logic [15:0] bd_a, bd_d, last_store;
  logic [15:0] ref_mem [logic [15:0]];
  vector_mem_sequencer_if b ();
  vector_mem_sequencer dut (.clk(clk), .reset(rst_n), .bus(b));
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_a] <= bd_d;
      valid[bd_a] <= 1'b1;
    end else if (b.mem_wren) begin
      ram[b.mem_address] <= b.mem_wdata;
      valid[b.mem_address] <= 1'b1;
    end
    b.mem_rdata <= valid[b.mem_address] ? ram[b.mem_address] : init_val(b.mem_address);
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  // Called at a negedge with the sequencer idle; walks the whole access cycle by cycle
  task automatic run(input bit wr, input logic [15:0] base, input logic [127:0] data,
                     input bit chg, input bit intrude, input int rst_at);
    int lat;
    logic [127:0] exp_v, prev;
    lat = wr ? 9 : 10;
    prev = vrd_ref;
    for (int i = 0; i < 8; i++) exp_v[i*16 +: 16] = ref_rd(16'(base + i));
    chk("ready_idle", b.req_ready, 1);
    b.req_valid = 1;
    b.req_write = wr;
    b.base_addr = base;
    b.vector_wdata = data;
    @(posedge clk);
    @(negedge clk);
    b.req_valid = 0;
    b.base_addr = 16'($urandom);
    if (chg) b.vector_wdata = '1;
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      if (intrude && c == 3) begin
        b.req_valid = 1;
        b.req_write = 0;
        b.base_addr = 16'h0040;
      end
      chk("wren", b.mem_wren, wr && c <= 8);
      chk("stall", b.stall, c < lat);
      chk("done", b.done, c == lat);
      chk("ready_busy", b.req_ready, c == lat ? 0 : 0);
      chk("vrd", b.vector_rdata, c == lat && !wr ? exp_v : prev);
      if (c <= 8) begin
        chk("addr", b.mem_address, 16'(base + c - 1));
        chk("wdata", b.mem_wdata, wr ? data[(c-1)*16 +: 16] : 16'h0);
      end
      if (c == lat) begin
        chk("addr_done", b.mem_address, 0);
        chk("wdata_done", b.mem_wdata, 0);
      end
      if (rst_at == c) begin
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", b.req_ready, 1);
        chk("rst_stall", b.stall, 0);
        chk("rst_done", b.done, 0);
        chk("rst_addr", b.mem_address, 0);
        chk("rst_wren", b.mem_wren, 0);
        chk("rst_vrd", b.vector_rdata, 0);
        rst_n = 1;
        vrd_ref = '0;
        return;
      end
    end
    if (wr) for (int i = 0; i < 8; i++) ref_mem[16'(base + i)] = data[i*16 +: 16];
    vrd_ref = wr ? prev : exp_v;
    @(negedge clk);
    chk("done_pulse", b.done, 0);
    chk("ready_after", b.req_ready, 1);
    chk("addr_idle", b.mem_address, 0);
  endtask
  initial begin
    total = 0;
    bad = 0;
    vrd_ref = '0;
    last_store = 16'h0010;
    b.req_valid = 0;
    b.req_write = 0;
    b.base_addr = '0;
    b.vector_wdata = '0;
    bd_we = 0;
    bd_a = '0;
    bd_d = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", b.req_ready, 1);
    chk("reset_stall", b.stall, 0);
    chk("reset_wren", b.mem_wren, 0);
    chk("reset_addr", b.mem_address, 0);
    chk("reset_wdata", b.mem_wdata, 0);
    chk("reset_vrd", b.vector_rdata, 0);
    chk("reset_done", b.done, 0);
    rst_n = 1;
    run(1, 16'h0010, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      bd_we = 1;
      bd_a = 16'h0010 + 16'(i);
      bd_d = 16'h00A0 + 16'(i);
      ref_mem[bd_a] = bd_d;
      @(negedge clk);
    end
    bd_we = 0;
    run(0, 16'h0010, '0, 0, 0, 0);
    chk("load_const", b.vector_rdata, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    wd = {$urandom, $urandom, $urandom, $urandom};
    run(1, 16'hFFFD, wd, 0, 0, 0);
    run(0, 16'hFFFD, '0, 0, 0, 0);
    chk("wrap_rt", b.vector_rdata, wd);
    wd = {$urandom, $urandom, $urandom, $urandom};
    run(1, 16'h0100, wd, 0, 1, 0);
    run(0, 16'h0040, '0, 0, 0, 0);
    run(0, 16'h0100, '0, 0, 0, 0);
    chk("busy_rt", b.vector_rdata, wd);
    run(0, 16'h0010, '0, 0, 0, 5);
    wd = {$urandom, $urandom, $urandom, $urandom};
    run(1, 16'h0200, wd, 1, 0, 0);
    run(0, 16'h0200, '0, 0, 0, 0);
    chk("stable_rt", b.vector_rdata, wd);
    for (int n = 0; n < 12; n++) begin
      bit w;
      logic [15:0] a;
      w = 1'($urandom_range(0, 1));
      a = n[0] ? last_store : 16'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      if (w) last_store = a;
      run(w, a, wd, 1'($urandom_range(0, 1)), 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
